// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter issuing a registered one-hot grant plus its binary index.
// Under contention a grant is released after MAX_HOLD cycles; a lone requester keeps its grant.
module decoder_rr_arbiter #(
    parameter int N_SEL    = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [(2**N_SEL)-1:0]   req,
    output logic [0:(2**N_SEL)-1]   gnt,
    output logic [N_SEL-1:0]        gnt_idx,
    output logic                    gnt_valid
);

    // state | meaning
    // IDLE  | no grant outstanding; arbitrate on the next edge
    // GRANT | gnt_idx owns the grant; hold_cnt counts its cycles
    localparam int R  = 2**N_SEL;
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [N_SEL-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [0:R-1]       gnt_q, gnt_d;
    logic [N_SEL-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;

    logic [N_SEL-1:0]   sel;
    logic [N_SEL-1:0]   cand;
    logic               found;
    logic [R-1:0]       own_mask;
    logic               others_req;

    // Search starts at ptr and wraps naturally in N_SEL bits.
    always_comb begin
        sel   = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < R; i++) begin
            cand = ptr_q + N_SEL'(i);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;

        own_mask             = '0;
        own_mask[gnt_idx_q]  = 1'b1;
        others_req           = |(req & ~own_mask);

        case (state_q)
            IDLE: begin
                if (en && (|req)) begin
                    state_d     = GRANT;
                    gnt_idx_d   = sel;
                    gnt_d       = '0;
                    gnt_d[sel]  = 1'b1;
                    gnt_valid_d = 1'b1;
                    ptr_d       = sel + N_SEL'(1);
                    hold_cnt_d  = '0;
                end else begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                end
            end
            GRANT: begin
                // Timeout only matters when someone else is waiting.
                if (!en || !req[gnt_idx_q] || ((hold_cnt_q == HOLD_LAST) && others_req)) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed and random checks of decoder_rr_arbiter against a cycle-level behavioural model.
module tb_decoder_rr_arbiter;

    localparam int N_SEL    = 3;
    localparam int MAX_HOLD = 4;
    localparam int R        = 2**N_SEL;

    logic             clk;
    logic             rst;
    logic             en;
    logic [R-1:0]     req;
    logic [0:R-1]     gnt;
    logic [N_SEL-1:0] gnt_idx;
    logic             gnt_valid;

    int n_cmp = 0;
    int n_err = 0;

    // model: who owns the grant, how many cycles it has been held, next search start
    int m_busy, m_owner, m_ptr, m_held;

    decoder_rr_arbiter #(.N_SEL(N_SEL), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_held  = 0;
    endtask

    task automatic model_edge();
        int others;
        int sel;
        if (rst) begin
            model_reset();
        end else if (m_busy == 0) begin
            if (en && req != 0) begin
                sel = -1;
                for (int k = 0; k < R; k++) begin
                    int c;
                    c = (m_ptr + k) % R;
                    if (sel < 0 && req[c]) sel = c;
                end
                m_owner = sel;
                m_ptr   = (sel + 1) % R;
                m_held  = 1;
                m_busy  = 1;
            end
        end else begin
            others = int'(req) & ~(1 << m_owner);
            if (!en || !req[m_owner] || (m_held >= MAX_HOLD && others != 0))
                m_busy = 0;
            else
                m_held++;
        end
    endtask

    task automatic compare_outputs();
        logic [R-1:0] obs;
        logic [R-1:0] exp_g;
        for (int k = 0; k < R; k++) obs[k] = gnt[k];
        exp_g = '0;
        if (m_busy != 0) exp_g[m_owner] = 1'b1;
        check_eq("gnt", 32'(obs), 32'(exp_g));
        check_eq("gnt_idx", 32'(gnt_idx), 32'(m_owner));
        check_eq("gnt_valid", 32'(gnt_valid), 32'(m_busy));
        check_eq("onehot", 32'($onehot0(obs)), 32'(1));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    // Called at edge+1; asserts reset mid-cycle and checks outputs clear before any edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("rst_gnt", 32'(gnt), 32'(0));
        check_eq("rst_idx", 32'(gnt_idx), 32'(0));
        check_eq("rst_valid", 32'(gnt_valid), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset_gnt", 32'(gnt), 32'(0));
        check_eq("reset_idx", 32'(gnt_idx), 32'(0));
        check_eq("reset_valid", 32'(gnt_valid), 32'(0));

        // basic grant and release
        en  = 1'b1;
        req = 8'h04;
        step();
        check_eq("basic_idx", 32'(gnt_idx), 32'(2));
        check_eq("basic_bit2", 32'(gnt[2]), 32'(1));
        req = 8'h00;
        step();
        check_eq("basic_release", 32'(gnt_valid), 32'(0));

        // full contention: order 0..7,0, four cycles each, one bubble between
        do_reset();
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < MAX_HOLD; c++) begin
                step();
                check_eq("cont_valid", 32'(gnt_valid), 32'(1));
                check_eq("cont_idx", 32'(gnt_idx), 32'(g % R));
            end
            step();
            check_eq("cont_bubble", 32'(gnt_valid), 32'(0));
        end

        // lone holder never times out
        do_reset();
        req = 8'h20;
        for (int c = 0; c < 20; c++) begin
            step();
            check_eq("lone_valid", 32'(gnt_valid), 32'(1));
            check_eq("lone_idx", 32'(gnt_idx), 32'(5));
        end
        req = 8'h00;
        step();

        // priority after pointer wrap
        do_reset();
        req = 8'h40;
        step();
        check_eq("wrap_first", 32'(gnt_idx), 32'(6));
        req = 8'h00;
        step();
        req = 8'h82;
        step();
        check_eq("wrap_7", 32'(gnt_idx), 32'(7));
        repeat (MAX_HOLD - 1) step();
        check_eq("wrap_7_held", 32'(gnt_valid), 32'(1));
        step();
        check_eq("wrap_bubble", 32'(gnt_valid), 32'(0));
        step();
        check_eq("wrap_1", 32'(gnt_idx), 32'(1));
        check_eq("wrap_1_valid", 32'(gnt_valid), 32'(1));

        // enable drop mid-grant
        do_reset();
        req = 8'h08;
        step();
        step();
        check_eq("endrop_held", 32'(gnt_idx), 32'(3));
        en = 1'b0;
        step();
        check_eq("endrop_off", 32'(gnt_valid), 32'(0));
        en = 1'b1;
        step();
        check_eq("endrop_regrant", 32'(gnt_valid), 32'(1));
        check_eq("endrop_idx", 32'(gnt_idx), 32'(3));

        // async reset during a grant, then first search from requester 0
        step();
        do_reset();
        req = 8'h09;
        step();
        check_eq("post_rst_idx", 32'(gnt_idx), 32'(0));

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    req = R'($urandom);
                2:       req = R'(1) << $urandom_range(0, R - 1);
                3:       req = req ^ (R'(1) << $urandom_range(0, R - 1));
                default: ;
            endcase
            en = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 299) == 0)
                do_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 Parameter N_SEL, default 3: width of the grant index; the requester count is R = 2**N_SEL.
REQ-002 Parameter MAX_HOLD, default 4: maximum number of grant cycles under contention; legal values are MAX_HOLD >= 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  arbiter enable; when low, no grant is issued or held.
REQ-006 req  input  [R-1:0]  request vector; req[k] = requester k.
REQ-007 gnt  output  [0:R-1]  registered one-hot grant; gnt[k] = requester k.
REQ-008 gnt_idx  output  [N_SEL-1:0]  registered binary index of the current or most recent grant.
REQ-009 gnt_valid  output  1  registered; high exactly when gnt is non-zero.

Function
REQ-010 The FSM SHALL have two states, IDLE and GRANT.
REQ-011 Internal state SHALL consist of rr pointer ptr[N_SEL-1:0] and hold counter hold_cnt, width ceil(log2(MAX_HOLD)) with a minimum of 1.
REQ-012 IDLE, en=1, req!=0: the next edge SHALL select the first set req bit searching ptr, ptr+1, ... mod R.
- At that edge: gnt_idx=sel, gnt bit sel only set, gnt_valid=1, ptr=sel+1 mod R (natural N_SEL-bit wrap), hold_cnt=0, state=GRANT.
REQ-013 IDLE with en=0 or req=0: state SHALL remain IDLE, gnt=0, gnt_valid=0, gnt_idx unchanged.
REQ-014 Latency: gnt_valid SHALL rise on the first rising edge at which IDLE samples a qualifying request (1 cycle).
REQ-015 GRANT SHALL exit to IDLE at the next edge, with gnt=0 and gnt_valid=0, if any of the following holds:
- en=0;
- req[gnt_idx]=0;
- hold_cnt==MAX_HOLD-1 and (req with bit gnt_idx masked) != 0.
REQ-016 Otherwise GRANT SHALL hold gnt, gnt_idx and gnt_valid, and hold_cnt SHALL increment, saturating at MAX_HOLD-1.
REQ-017 A lone requester SHALL keep its grant indefinitely while it holds req and en=1.
REQ-018 Under contention, each grant SHALL last exactly MAX_HOLD cycles, followed by exactly one IDLE bubble cycle before the next grant.
REQ-019 gnt SHALL always be zero or one-hot and SHALL equal the decode of gnt_idx whenever gnt_valid=1.
REQ-020 Requests asserted or dropped by non-granted requesters during GRANT SHALL NOT affect the current grant, except through the timeout term in REQ-015.
REQ-021 The ptr wrap from R-1 to 0 SHALL give requester 0 the highest priority in the next IDLE search.

Reset
REQ-022 rst=1 SHALL immediately, without a clock edge, force: state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, ptr=0, hold_cnt=0.
REQ-023 Reset asserted mid-grant SHALL abort the grant; after release, the first arbitration SHALL start the search at requester 0.
REQ-024 The first edge after rst falls SHALL be a normal IDLE evaluation.

Verification (N_SEL=3, MAX_HOLD=4 unless stated)
REQ-025 Basic grant: reset, then en=1, req=8'h04 -> one edge later gnt[2]=1, gnt_idx=3'd2, gnt_valid=1; drop req -> next edge gnt=0, gnt_valid=0.
REQ-026 Full contention: req=8'hFF held -> grant order 0,1,...,7,0; each grant lasts 4 cycles, with 1 IDLE cycle between grants.
REQ-027 Lone holder: req=8'h20 held for 20 cycles -> gnt_idx=5 with gnt_valid=1 continuously, no timeout release.
REQ-028 Priority after wrap: grant requester 6 then release it; next apply req=8'h82 -> grant 7 first, then requester 1 after requester 7 releases or times out.
REQ-029 Enable drop: mid-grant to requester 3, en=0 -> next edge gnt=0 and state IDLE; en=1 with req=8'h08 still held -> requester 3 is re-granted one edge later.
REQ-030 Async reset: assert rst between edges during a grant -> gnt, gnt_valid and gnt_idx read 0 before the next clk edge.
